axis_route_tagger: RTL and testbench
====================================

AXIS_ROUTE_TAGGER -- requirements
Module: axis_route_tagger

Interface
REQ-001 Parameter DATA_BITS, default 512, tdata width in bits; tkeep width SHALL be DATA_BITS/8.
REQ-002 Parameter PID_BITS, default 6, tid width in bits.
REQ-003 Parameter DEST_BITS, default 8, route/tdest width in bits.
REQ-004 Parameter DROP_ROUTE, default all-ones of DEST_BITS, route value meaning "unroutable, discard".
REQ-005 Port aclk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 Port areset, input, 1, reset; asynchronous and active-high.
REQ-007 Port route_cfg, input, DEST_BITS, current route for this region, sampled only at start of packet.
REQ-008 Ports s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast/s_tid, in/out/in/in/in/in, 1/1/DATA_BITS/DATA_BITS/8/1/PID_BITS, AXI4-Stream input from user logic.
REQ-009 Ports m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tid/m_tdest, out/in/out/out/out/out/out, 1/1/DATA_BITS/DATA_BITS/8/1/PID_BITS/DEST_BITS, tagged stream toward the 6x6 data switch slave port.
REQ-010 Port pkt_cnt, output, 32, packets forwarded (counted on tlast handshake at m side).
REQ-011 Port drop_cnt, output, 32, packets discarded.
REQ-012 Port busy, output, 1, high while a packet is mid-flight on the input (state PASS or DROP).

Function
REQ-013 FSM states IDLE, PASS, DROP; IDLE is the start-of-packet state.
REQ-014 IDLE, input handshake, route_cfg != DROP_ROUTE: latch route_cfg into pkt_route; beat forwarded with tdest=route_cfg; go PASS unless s_tlast (stay IDLE).
REQ-015 IDLE, input handshake, route_cfg == DROP_ROUTE: beat discarded; go DROP unless s_tlast (stay IDLE); drop_cnt increments once per packet at this beat.
REQ-016 PASS: every beat forwarded with tdest=pkt_route; route_cfg changes mid-packet SHALL have no effect; s_tlast handshake returns to IDLE.
REQ-017 DROP: s_tready held 1, beats discarded, nothing written to buffer; s_tlast handshake returns to IDLE.
REQ-018 Output path SHALL be a 2-entry skid buffer; data/keep/last/id/dest travel together per entry.
REQ-019 Latency: beat accepted at cycle N appears on m_* at cycle N+1 (m_tvalid high) when buffer was empty.
REQ-020 Throughput: one beat per cycle sustained while m_tready=1.
REQ-021 s_tready SHALL be a register output: 1 in IDLE/PASS when buffer holds at most 1 entry, 0 when 2 entries; always 1 in DROP; no combinational path m_tready->s_tready.
REQ-022 Simultaneous push and pop on a 1-entry buffer: occupancy unchanged, order preserved.
REQ-023 m_* outputs SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 Counters SHALL saturate at 32'hFFFF_FFFF, not wrap.
REQ-025 pkt_cnt increments on m_tvalid&m_tready&m_tlast; drop_cnt per REQ-015; both may increment in the same cycle.
REQ-026 s_tvalid low never changes state; beats with tkeep=0 are forwarded unchanged.

Reset
REQ-027 areset high SHALL immediately force: state IDLE, buffer empty, m_tvalid=0, s_tready=0, busy=0, pkt_cnt=0, drop_cnt=0, pkt_route=0.
REQ-028 First cycle after areset deasserts s_tready SHALL become 1.
REQ-029 Reset mid-packet: partial packet lost, no counter increment; next accepted beat treated as start of packet.

Verification
REQ-030 route_cfg=8'h7C, 4-beat packet, m_tready=1 -> 4 beats out, all m_tdest=8'h7C, beat1 at N+1, pkt_cnt=1.
REQ-031 route_cfg changes 8'h7C->8'h9C after beat 1 of 4-beat packet -> all 4 beats tdest=8'h7C; next packet tdest=8'h9C.
REQ-032 route_cfg=8'hFF, 3-beat packet -> s_tready=1 all 3 cycles, no m_tvalid, drop_cnt=1, pkt_cnt=0.
REQ-033 m_tready=0 for 5 cycles during 8-beat packet -> s_tready falls after 2 buffered beats, no loss/duplication, order intact, m_* stable while stalled.
REQ-034 Random s_tvalid/m_tready at 50% over 1000 packets of 1-16 beats -> output equals input minus dropped packets; pkt_cnt+drop_cnt=1000.
REQ-035 areset pulsed mid beat 2 of 5 -> m_tvalid=0 immediately, counters 0, next packet tagged with then-current route_cfg.

Source files
------------

// File: rtl/axis_route_tagger_if.sv
// AXI4-Stream bundle shared by the tagger's input and output sides.
// The input side carries no tdest; the tagger supplies it on the output side.
interface axis_route_tagger_if #(
    parameter int DATA_BITS = 512,
    parameter int PID_BITS  = 6,
    parameter int DEST_BITS = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [PID_BITS-1:0]    tid;
    logic [DEST_BITS-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/axis_route_tagger.sv
// Tags each packet with the route sampled at its first beat and forwards it
// through a 2-entry skid buffer; packets routed to DROP_ROUTE are discarded.
module axis_route_tagger #(
    parameter int                   DATA_BITS  = 512,
    parameter int                   PID_BITS   = 6,
    parameter int                   DEST_BITS  = 8,
    parameter logic [DEST_BITS-1:0] DROP_ROUTE = {DEST_BITS{1'b1}}
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [DEST_BITS-1:0] route_cfg,
    axis_route_tagger_if.slave   s_axis,
    axis_route_tagger_if.master  m_axis,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          drop_cnt,
    output logic                 busy
);
    localparam int KEEP_BITS = DATA_BITS / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [KEEP_BITS-1:0] keep;
        logic                 last;
        logic [PID_BITS-1:0]  id;
        logic [DEST_BITS-1:0] dest;
    } beat_t;

    logic [1:0]           state_reg, state_next;
    logic [DEST_BITS-1:0] pkt_route_reg, pkt_route_next;
    logic [1:0]           count_reg, count_next;
    logic                 s_ready_reg, s_ready_next;
    logic [31:0]          pkt_cnt_reg, drop_cnt_reg;
    beat_t                buf_reg [2];
    beat_t                new_beat;

    logic                 s_hs;
    logic                 push;
    logic                 pop;
    logic                 drop_start;
    logic [DEST_BITS-1:0] push_dest;

    assign s_hs = s_axis.tvalid & s_ready_reg;
    assign pop  = (count_reg != 2'd0) & m_axis.tready;

    always_comb begin
        state_next     = state_reg;
        pkt_route_next = pkt_route_reg;
        push           = 1'b0;
        push_dest      = pkt_route_reg;
        drop_start     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_hs) begin
                    if (route_cfg == DROP_ROUTE) begin
                        drop_start = 1'b1;
                        if (!s_axis.tlast) state_next = DROP;
                    end else begin
                        pkt_route_next = route_cfg;
                        push           = 1'b1;
                        push_dest      = route_cfg;
                        if (!s_axis.tlast) state_next = PASS;
                    end
                end
            end
            PASS: begin
                if (s_hs) begin
                    push = 1'b1;
                    if (s_axis.tlast) state_next = IDLE;
                end
            end
            DROP: begin
                if (s_hs && s_axis.tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign new_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast,
                        id: s_axis.tid, dest: push_dest};

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Ready is registered from next-cycle occupancy so m_tready never reaches s_tready combinationally.
    assign s_ready_next = (state_next == DROP) || (count_next != 2'd2);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg     <= IDLE;
            pkt_route_reg <= '0;
            count_reg     <= 2'd0;
            s_ready_reg   <= 1'b0;
            pkt_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pkt_route_reg <= pkt_route_next;
            count_reg     <= count_next;
            s_ready_reg   <= s_ready_next;
            if (pop && buf_reg[0].last && (pkt_cnt_reg != 32'hFFFF_FFFF))
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            if (drop_start && (drop_cnt_reg != 32'hFFFF_FFFF))
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward or refills from the input.
    always_ff @(posedge aclk) begin
        if (pop) begin
            buf_reg[0] <= (count_reg == 2'd2) ? buf_reg[1] : new_beat;
            if (push) buf_reg[1] <= new_beat;
        end else if (push) begin
            if (count_reg == 2'd0) buf_reg[0] <= new_beat;
            else                   buf_reg[1] <= new_beat;
        end
    end

    assign s_axis.tready = s_ready_reg;
    assign m_axis.tvalid = (count_reg != 2'd0);
    assign m_axis.tdata  = buf_reg[0].data;
    assign m_axis.tkeep  = buf_reg[0].keep;
    assign m_axis.tlast  = buf_reg[0].last;
    assign m_axis.tid    = buf_reg[0].id;
    assign m_axis.tdest  = buf_reg[0].dest;

    assign pkt_cnt  = pkt_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
    assign busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_axis_route_tagger.sv
// Scoreboard bench for axis_route_tagger: the driver records expected beats per
// packet route, a negedge monitor pops and compares every output handshake.
module tb_axis_route_tagger;
    localparam int DB = 512;
    localparam int PB = 6;
    localparam int DD = 8;
    localparam int KB = DB / 8;
    localparam logic [7:0] DROP = 8'hFF;
    localparam int BUSW = DB + KB + 1 + PB + DD;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic [7:0]  route_cfg;
    logic [31:0] pkt_cnt, drop_cnt;
    logic        busy;

    axis_route_tagger_if #(.DATA_BITS(DB), .PID_BITS(PB), .DEST_BITS(DD)) s_if();
    axis_route_tagger_if #(.DATA_BITS(DB), .PID_BITS(PB), .DEST_BITS(DD)) m_if();

    axis_route_tagger #(.DATA_BITS(DB), .PID_BITS(PB), .DEST_BITS(DD)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .route_cfg (route_cfg),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DB-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        logic [PB-1:0] id;
        logic [7:0]    dest;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mrdy_mode = 0;
    int valid_pct = 100;
    int acc_beats = 0;
    int first_acc = 0;
    int last_acc = 0;
    int lat_min = 1000;
    int lat_max = 0;
    int mv_cnt = 0;
    int exp_pkts = 0;
    int exp_drops = 0;
    int pkt_no = 0;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (mrdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: scoreboard pop on every output handshake plus hold-while-stalled check.
    initial begin
        logic            prev_stall;
        logic [BUSW-1:0] prev_bus, cur_bus;
        exp_t            e;
        int              lat;
        prev_stall = 1'b0;
        prev_bus   = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                cur_bus = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest};
                if (m_if.tvalid) mv_cnt++;
                if (prev_stall) begin
                    checks++;
                    if (cur_bus !== prev_bus || !m_if.tvalid) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b dest=%h expected valid=1 dest=%h",
                                 m_if.tvalid, m_if.tdest, prev_bus[7:0]);
                    end
                end
                if (m_if.tvalid && m_if.tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_extra: got beat dest=%h last=%b expected none",
                                 m_if.tdest, m_if.tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_if.tdata !== e.data || m_if.tkeep !== e.keep || m_if.tlast !== e.last ||
                            m_if.tid !== e.id || m_if.tdest !== e.dest) begin
                            errors++;
                            $display("FAIL scoreboard_beat: got dest=%h last=%b id=%h data=%h expected dest=%h last=%b id=%h data=%h",
                                     m_if.tdest, m_if.tlast, m_if.tid, m_if.tdata[63:0],
                                     e.dest, e.last, e.id, e.data[63:0]);
                        end
                        lat = cyc - e.acc_cyc;
                        if (lat < lat_min) lat_min = lat;
                        if (lat > lat_max) lat_max = lat;
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_bus   = cur_bus;
            end
        end
    end

    task automatic rand_fields(input bit last);
        for (int i = 0; i < DB / 32; i++) s_if.tdata[i*32 +: 32] = $urandom;
        s_if.tkeep = ($urandom_range(9) == 0) ? '0 : {$urandom, $urandom};
        s_if.tlast = last;
        s_if.tid   = PB'($urandom);
    endtask

    // Presents one beat and waits (bounded) for the handshake; rt is the packet's sampled route.
    task automatic send_beat(input logic [7:0] rt, input bit last);
        bit   ok;
        int   n;
        exp_t e;
        while ($urandom_range(99) >= valid_pct) begin
            s_if.tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        rand_fields(last);
        s_if.tvalid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 2000) begin
            @(negedge aclk);
            if (s_if.tready) begin
                ok = 1'b1;
                e.data = s_if.tdata; e.keep = s_if.tkeep; e.last = s_if.tlast;
                e.id = s_if.tid; e.dest = rt; e.acc_cyc = cyc;
                if (rt != DROP) exp_q.push_back(e);
                acc_beats++;
                if (acc_beats == 1) first_acc = cyc;
                last_acc = cyc;
            end
            @(posedge aclk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_tready in %0d cycles expected handshake", n);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] rt, input int nb, input logic [7:0] rt_after);
        route_cfg = rt;
        for (int b = 0; b < nb; b++) begin
            send_beat(rt, b == nb - 1);
            if (b == 0) route_cfg = rt_after;
        end
        if (rt == DROP) exp_drops++;
        else            exp_pkts++;
        pkt_no++;
        $display("pkt %0d route %h beats %0d route_after %h", pkt_no, rt, nb, rt_after);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_busy",     64'(busy),        64'd0);
        chk("rst_pkt_cnt",  64'(pkt_cnt),     64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt),    64'd0);
        exp_q.delete();
        exp_pkts  = 0;
        exp_drops = 0;
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("first_cycle_s_tready", 64'(s_if.tready), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        route_cfg   = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        #3;
        do_reset();

        // Single packet, ready held high: one-cycle latency and back-to-back acceptance.
        mrdy_mode = 0; valid_pct = 100; acc_beats = 0; lat_min = 1000; lat_max = 0;
        send_pkt(8'h7C, 4, 8'h7C);
        chk("t030_accept_span", 64'(last_acc - first_acc), 64'd3);
        drain();
        chk("t030_lat_min", 64'(lat_min), 64'd1);
        chk("t030_lat_max", 64'(lat_max), 64'd1);
        chk("t030_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));

        // Route change mid-packet must not affect the packet in flight.
        send_pkt(8'h7C, 4, 8'h9C);
        send_pkt(8'h9C, 3, 8'h9C);
        drain();
        chk("t031_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Dropped packet: accepted every cycle, nothing on the output.
        begin
            int mv0;
            mv0 = mv_cnt; acc_beats = 0;
            send_pkt(DROP, 3, DROP);
            chk("t032_accept_span", 64'(last_acc - first_acc), 64'd2);
            repeat (3) @(posedge aclk);
            #1;
            chk("t032_no_m_tvalid", 64'(mv_cnt - mv0), 64'd0);
            chk("t032_drop_cnt", 64'(drop_cnt), 64'd1);
            chk("t032_pkt_cnt",  64'(pkt_cnt),  64'd3);
        end

        // Output stall: two beats buffered, then input backpressure.
        mrdy_mode = 2;
        @(posedge aclk);
        #1;
        acc_beats = 0;
        fork
            send_pkt(8'h5A, 8, 8'h11);
            begin
                repeat (5) @(negedge aclk);
                chk("t033_s_tready", 64'(s_if.tready), 64'd0);
                chk("t033_buffered", 64'(acc_beats),   64'd2);
                chk("t033_m_tvalid", 64'(m_if.tvalid), 64'd1);
                chk("t033_busy",     64'(busy),        64'd1);
                mrdy_mode = 0;
            end
        join
        drain();
        chk("t033_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // Reset in the middle of beat 2 of a 5-beat packet.
        route_cfg = 8'h7C;
        acc_beats = 0;
        send_beat(8'h7C, 1'b0);
        rand_fields(1'b0);
        s_if.tvalid = 1'b1;
        #3;
        route_cfg = 8'h3A;
        do_reset();
        send_pkt(8'h3A, 2, 8'h44);
        drain();
        chk("t035_pkt_cnt",  64'(pkt_cnt),  64'd1);
        chk("t035_drop_cnt", 64'(drop_cnt), 64'd0);

        // Randomized traffic: 1000 packets, 50% valid and ready.
        do_reset();
        mrdy_mode = 1;
        valid_pct = 50;
        for (int p = 0; p < 1000; p++) begin
            logic [7:0] rt, ra;
            rt = ($urandom_range(4) == 0) ? DROP : 8'($urandom_range(254));
            ra = ($urandom_range(3) == 0) ? DROP : 8'($urandom_range(254));
            send_pkt(rt, $urandom_range(1, 16), ra);
        end
        mrdy_mode = 0;
        drain();
        chk("rand_pkt_cnt",  64'(pkt_cnt),  64'(exp_pkts));
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        chk("rand_total",    64'(pkt_cnt) + 64'(drop_cnt), 64'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
